// File: rtl/nibble_serial_addsub.sv
// Wide two's-complement add/subtract built from one 4-bit slice reused over
// NIBBLES cycles, with the carry chained between nibbles and a start/done handshake.
module nibble_serial_addsub #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] S,
  output logic         Cout,
  output logic         ovf
);

  // state | meaning
  // IDLE  | waiting for start; result of the previous operation held
  // RUN   | one nibble per cycle through the slice, LSB nibble first
  // DONE  | one-cycle done pulse, result valid
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int             CW   = $clog2(NIBBLES);
  localparam logic [CW-1:0]  LAST = CW'(NIBBLES - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  s_q, s_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [CW+1:0] bit_idx;
  logic [3:0]    a_nib;
  logic [3:0]    d_nib;
  logic [4:0]    sum5;
  logic          c3;

  always_comb begin
    bit_idx = {cnt_q, 2'b00};
    a_nib   = a_q[bit_idx +: 4];
    d_nib   = b_q[bit_idx +: 4] ^ {4{mode_q}};
    sum5    = {1'b0, a_nib} + {1'b0, d_nib} + {4'b0000, carry_q};
    // carry into the slice MSB recovered from the MSB sum bit
    c3      = a_nib[3] ^ d_nib[3] ^ sum5[3];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B;
          mode_d  = mode;
          carry_d = mode;
          cnt_d   = '0;
          s_d     = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        s_d[bit_idx +: 4] = sum5[3:0];
        carry_d           = sum5[4];
        cnt_d             = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          cout_d  = sum5[4];
          ovf_d   = c3 ^ sum5[4];
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Randomized and directed bench for nibble_serial_addsub (4- and 2-nibble builds)
// against a plain-arithmetic reference model.
module tb_nibble_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, cout, ovf;
  logic [15:0] s;

  logic        start2 = 1'b0;
  logic        mode2 = 1'b0;
  logic [7:0]  a2 = '0;
  logic [7:0]  b2 = '0;
  logic        busy2, done2, cout2, ovf2;
  logic [7:0]  s2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_addsub #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .A(a), .B(b),
    .busy(busy), .done(done), .S(s), .Cout(cout), .ovf(ovf)
  );

  nibble_serial_addsub #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .A(a2), .B(b2),
    .busy(busy2), .done(done2), .S(s2), .Cout(cout2), .ovf(ovf2)
  );

  // Reference: integer arithmetic on w-bit operands.
  function automatic void ref_model(input int w, input logic [15:0] ra, input logic [15:0] rb,
                                    input logic m, output logic [15:0] rs,
                                    output logic rco, output logic rov);
    longint ua, ub, sa, sb, full, sres, half;
    ua   = longint'(ra) & ((64'sd1 <<< w) - 1);
    ub   = longint'(rb) & ((64'sd1 <<< w) - 1);
    half = 64'sd1 <<< (w - 1);
    sa   = (ua >= half) ? ua - (64'sd1 <<< w) : ua;
    sb   = (ub >= half) ? ub - (64'sd1 <<< w) : ub;
    if (m) begin
      full = ua - ub;
      rco  = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = ua + ub;
      rco  = (full >= (64'sd1 <<< w));
      sres = sa + sb;
    end
    rs  = 16'(full & ((64'sd1 <<< w) - 1));
    rov = (sres >= half) || (sres < -half);
  endfunction

  task automatic run_op4(input logic [15:0] ta, input logic [15:0] tb_, input logic tm,
                         input string name);
    logic [15:0] es;
    logic eco, eov;
    ref_model(16, ta, tb_, tm, es, eco, eov);
    @(negedge clk);
    a = ta; b = tb_; mode = tm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", name, busy, done);
    end
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== (c == 4) || busy !== (c <= 4)) begin
        errors++;
        $display("FAIL %s cycle %0d: busy=%b done=%b required busy=%b done=%b",
                 name, c, busy, done, c <= 4, c == 4);
      end
      if (c >= 4) begin
        checks++;
        if (s !== es || cout !== eco || ovf !== eov) begin
          errors++;
          $display("FAIL %s result c%0d: S=%h Cout=%b ovf=%b required S=%h Cout=%b ovf=%b",
                   name, c, s, cout, ovf, es, eco, eov);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom); start = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || s !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: busy=%b done=%b S=%h Cout=%b ovf=%b required all 0",
                 busy, done, s, cout, ovf);
      end
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || s !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL reset_release: busy=%b done=%b S=%h Cout=%b ovf=%b required all 0",
                 busy, done, s, cout, ovf);
      end
    end
  endtask

  task automatic test_add;
    run_op4(16'h1234, 16'h4321, 1'b0, "add_5555");
    run_op4(16'hFFFF, 16'h0001, 1'b0, "add_wrap");
    run_op4(16'h7FFF, 16'h0001, 1'b0, "add_ovf");
  endtask

  task automatic test_sub;
    run_op4(16'h0005, 16'h000E, 1'b1, "sub_borrow");
    run_op4(16'h8000, 16'h0001, 1'b1, "sub_ovf");
    run_op4(16'h0006, 16'h0002, 1'b1, "sub_small");
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++)
      run_op4(16'($urandom), 16'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_latch_ignore;
    int dcount = 0;
    @(negedge clk);
    a = 16'h0101; b = 16'h0101; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) begin
        a = 16'hABCD; b = 16'h1357; mode = 1'b1; start = 1'b1;
      end else if (c == 3) begin
        start = 1'b0; a = 16'h0F0F;
      end
      @(posedge clk); #1;
      if (done === 1'b1) dcount++;
      checks++;
      if (done !== (c == 4) || busy !== (c <= 4)) begin
        errors++;
        $display("FAIL latch cycle %0d: busy=%b done=%b required busy=%b done=%b",
                 c, busy, done, c <= 4, c == 4);
      end
    end
    checks++;
    if (s !== 16'h0202 || dcount != 1) begin
      errors++;
      $display("FAIL latch result: S=%h done_pulses=%0d required S=0202 done_pulses=1", s, dcount);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    a = 16'h4444; b = 16'h1111; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || s !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b S=%h Cout=%b ovf=%b required all 0",
               busy, done, s, cout, ovf);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_nodone: busy=%b done=%b required 0 0", busy, done);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: busy=%b done=%b required 0 0", busy, done);
    end
    run_op4(16'h1111, 16'h2222, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back;
    logic [15:0] qa, qb, es;
    logic qm, eco, eov;
    qa = '0; qb = '0; qm = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom); start = 1'b1;
      @(posedge clk);
      if (cyc % 6 == 0) begin
        qa = a; qb = b; qm = mode;
      end
      #1;
      checks++;
      if (done !== (cyc % 6 == 4) || busy !== (cyc % 6 <= 4)) begin
        errors++;
        $display("FAIL b2b cycle %0d: busy=%b done=%b required busy=%b done=%b",
                 cyc, busy, done, cyc % 6 <= 4, cyc % 6 == 4);
      end
      if (cyc % 6 == 4) begin
        ref_model(16, qa, qb, qm, es, eco, eov);
        checks++;
        if (s !== es || cout !== eco || ovf !== eov) begin
          errors++;
          $display("FAIL b2b result %0d: S=%h Cout=%b ovf=%b required S=%h Cout=%b ovf=%b",
                   cyc, s, cout, ovf, es, eco, eov);
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_nibbles2;
    logic [15:0] es;
    logic eco, eov;
    logic [7:0] ta, tb_;
    logic tm;
    for (int n = 0; n < 6; n++) begin
      if (n == 0) begin
        ta = 8'hFF; tb_ = 8'h01; tm = 1'b0;
      end else begin
        ta = 8'($urandom); tb_ = 8'($urandom); tm = 1'($urandom);
      end
      ref_model(8, {8'h00, ta}, {8'h00, tb_}, tm, es, eco, eov);
      @(negedge clk);
      a2 = ta; b2 = tb_; mode2 = tm; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        @(posedge clk); #1;
        checks++;
        if (done2 !== (c == 2) || busy2 !== (c <= 2)) begin
          errors++;
          $display("FAIL n2 cycle %0d: busy=%b done=%b required busy=%b done=%b",
                   c, busy2, done2, c <= 2, c == 2);
        end
        if (c == 2) begin
          checks++;
          if (s2 !== es[7:0] || cout2 !== eco || ovf2 !== eov) begin
            errors++;
            $display("FAIL n2 result: S=%h Cout=%b ovf=%b required S=%h Cout=%b ovf=%b",
                     s2, cout2, ovf2, es[7:0], eco, eov);
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_latch_ignore();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_nibbles2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
